// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions used by the PC, fetch queue and decode stages.
//   ADDR_W        instruction address width
//   INSTR_W       instruction word width
//   NOP_INSTR     word presented to decode when nothing valid is available
//   fetch_entry_t one fetched word together with the address it came from
package fetch_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping queue pointer for the fetch queue.
//   clk    rising-edge clock
//   reset  synchronous active-low reset, forces the pointer to 0
//   clr    synchronous clear to 0 (branch flush), wins over inc
//   inc    advance by one; wraps naturally because the depth is a power of two
//   ptr    current pointer value
module fq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch buffer between instruction memory and decode.
//   clk        rising-edge clock
//   reset      synchronous active-low reset, clears count and pointers
//   in_valid   fetch side presents in_pc/in_instr
//   in_pc      address of the fetched word
//   in_instr   fetched word
//   in_ready   queue can accept a word (inverse drives the PC stall)
//   out_valid  head entry is valid
//   out_pc     address of the head entry (0 when empty)
//   out_instr  head instruction (NOP when empty)
//   out_ready  decode consumes the head this cycle
//   flush      taken branch, discard every entry
//   count      number of occupied entries
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    import fetch_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Handshake flags depend only on the registered count, so in_ready never
    // has a combinational path from out_ready (a full queue refuses a word
    // even when the head leaves in the same cycle).
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    fq_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fq_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity lives entirely in
    // count/pointers, so clearing the data would only add reset fan-out.
    // A write that coincides with flush or reset lands in a slot that the
    // cleared pointers already treat as free, so it is harmless.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // NOTE: every signal driven here gets a value on every path so no latch
    // is inferred.
    always_comb begin
        head      = mem[rd_ptr];
        out_pc    = '0;
        out_instr = INSTR_W'(NOP_INSTR);
        if (out_valid) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end
    end

endmodule
